adc_meas_accum: RTL and testbench

//  Acquisition stage between the dual 12-bit ADC pins and the SPI readout path.
//  On a start command it captures a programmed number of A/B sample pairs and

---
 rtl/adc_meas_accum_pkg.sv | 27 ++
 rtl/adc_meas_accum_if.sv | 34 +++
 rtl/adc_meas_accum_ch.sv | 52 +++++
 rtl/adc_meas_accum.sv | 140 ++++++++++++++
 tb/tb_adc_meas_accum.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_meas_accum_pkg.sv
// Shared constants, FSM encoding and read-map helpers for the ADC measurement accumulator.
package adc_meas_accum_pkg;

  localparam int unsigned ADC_W_DEF = 12;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned RD_ADDR_W = 3;
  localparam int unsigned RD_DATA_W = 8;
  localparam int unsigned RD_LANE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_ACQ  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Read map: addresses 0-3 are res_a bytes LSB..MSB, 4-7 the same for res_b.
  function automatic logic rd_is_b(input logic [RD_ADDR_W-1:0] addr);
    return addr[RD_ADDR_W-1];
  endfunction

  function automatic logic [RD_LANE_W-1:0] rd_lane(input logic [RD_ADDR_W-1:0] addr);
    return addr[RD_LANE_W-1:0];
  endfunction

endpackage

// File: rtl/adc_meas_accum_if.sv
// Sample, control, result and byte-readout signals of the ADC measurement accumulator.
interface adc_meas_accum_if
  import adc_meas_accum_pkg::*;
#(
  parameter int unsigned ADC_W = ADC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) ();

  logic                 adc_valid;
  logic [ADC_W-1:0]     adc_a;
  logic [ADC_W-1:0]     adc_b;
  logic                 start;
  logic                 abort;
  logic [CNT_W-1:0]     num_samples;
  logic                 busy;
  logic                 meas_done;
  logic                 clip;
  logic [ACC_W-1:0]     res_a;
  logic [ACC_W-1:0]     res_b;
  logic [RD_ADDR_W-1:0] rd_addr;
  logic [RD_DATA_W-1:0] rd_data;

  modport master (
    output adc_valid, adc_a, adc_b, start, abort, num_samples, rd_addr,
    input  busy, meas_done, clip, res_a, res_b, rd_data
  );

  modport slave (
    input  adc_valid, adc_a, adc_b, start, abort, num_samples, rd_addr,
    output busy, meas_done, clip, res_a, res_b, rd_data
  );

endinterface

// File: rtl/adc_meas_accum_ch.sv
// One accumulation channel: offset-binary to signed, sign-extend, accumulate, sticky clip detect.
module adc_meas_accum_ch
  import adc_meas_accum_pkg::*;
#(
  parameter int unsigned ADC_W = ADC_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             clear_c,
  input  logic             add_c,
  input  logic [ADC_W-1:0] sample,
  output logic [ACC_W-1:0] acc,
  output logic             clip
);

  logic [ADC_W-1:0] smp_s;
  logic [ACC_W-1:0] smp_ext;
  logic             hit;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             clip_d, clip_q;

  // Clear has priority: a new measurement never inherits a stale sample.
  always_comb begin
    smp_s   = {~sample[ADC_W-1], sample[ADC_W-2:0]};
    smp_ext = {{(ACC_W-ADC_W){smp_s[ADC_W-1]}}, smp_s};
    hit     = (sample == '0) || (sample == '1);
    acc_d   = acc_q;
    clip_d  = clip_q;
    if (clear_c) begin
      acc_d  = '0;
      clip_d = 1'b0;
    end else if (add_c) begin
      acc_d  = acc_q + smp_ext;
      clip_d = clip_q | hit;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      acc_q  <= '0;
      clip_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      clip_q <= clip_d;
    end
  end

  assign acc  = acc_q;
  assign clip = clip_q;

endmodule

// File: rtl/adc_meas_accum.sv
// Dual-channel ADC measurement: counted capture of A/B sample pairs into signed sums,
// result latch on completion and a registered byte mux for the SPI readout side.
module adc_meas_accum
  import adc_meas_accum_pkg::*;
#(
  parameter int unsigned ADC_W = ADC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input logic             sys_clk,
  input logic             rst,
  adc_meas_accum_if.slave bus
);

  if (ACC_W < ADC_W + CNT_W) begin : g_width_chk
    $fatal(1, "adc_meas_accum: ACC_W must be at least ADC_W + CNT_W");
  end

  state_e               state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 adc_valid_q;
  logic [ADC_W-1:0]     adc_a_q, adc_b_q;
  logic                 busy_d, busy_q;
  logic                 meas_done_d, meas_done_q;
  logic                 clip_d, clip_q;
  logic [ACC_W-1:0]     res_a_d, res_a_q;
  logic [ACC_W-1:0]     res_b_d, res_b_q;
  logic [RD_DATA_W-1:0] rd_data_d, rd_data_q;
  logic [ACC_W-1:0]     rd_word;

  logic                 clear_c, add_c;
  logic [ACC_W-1:0]     acc_a, acc_b;
  logic                 clip_a, clip_b;

  adc_meas_accum_ch #(.ADC_W(ADC_W), .ACC_W(ACC_W)) u_ch_a (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clear_c (clear_c),
    .add_c   (add_c),
    .sample  (adc_a_q),
    .acc     (acc_a),
    .clip    (clip_a)
  );

  adc_meas_accum_ch #(.ADC_W(ADC_W), .ACC_W(ACC_W)) u_ch_b (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clear_c (clear_c),
    .add_c   (add_c),
    .sample  (adc_b_q),
    .acc     (acc_b),
    .clip    (clip_b)
  );

  // Completion is taken one cycle after the final add (cnt reaches zero), so the
  // latched sums always include the last sample; ARM with N=0 uses the same exit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clear_c     = 1'b0;
    add_c       = 1'b0;
    meas_done_d = 1'b0;
    clip_d      = clip_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          state_d = ST_ARM;
          cnt_d   = bus.num_samples;
          clear_c = 1'b1;
        end
      end
      ST_ARM, ST_ACQ: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d     = ST_DONE;
          meas_done_d = 1'b1;
          res_a_d     = acc_a;
          res_b_d     = acc_b;
          clip_d      = clip_a | clip_b;
        end else if (state_q == ST_ARM) begin
          state_d = ST_ACQ;
        end else if (adc_valid_q) begin
          add_c = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ARM) || (state_d == ST_ACQ);
  end

  // Byte readout is independent of the FSM; results only move on completion.
  always_comb begin
    rd_word   = rd_is_b(bus.rd_addr) ? res_b_q : res_a_q;
    rd_data_d = RD_DATA_W'(rd_word >> {rd_lane(bus.rd_addr), 3'b000});
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      adc_valid_q <= 1'b0;
      adc_a_q     <= '0;
      adc_b_q     <= '0;
      busy_q      <= 1'b0;
      meas_done_q <= 1'b0;
      clip_q      <= 1'b0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adc_valid_q <= bus.adc_valid;
      adc_a_q     <= bus.adc_a;
      adc_b_q     <= bus.adc_b;
      busy_q      <= busy_d;
      meas_done_q <= meas_done_d;
      clip_q      <= clip_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.meas_done = meas_done_q;
  assign bus.clip      = clip_q;
  assign bus.res_a     = res_a_q;
  assign bus.res_b     = res_b_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_adc_meas_accum.sv
// Self-checking bench for adc_meas_accum: randomized sample streams against a sum-of-samples model.
module tb_adc_meas_accum;

  localparam int unsigned ADC_W = 12;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ACC_W = 32;

  logic sys_clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [ACC_W-1:0] exp_res_a = '0;
  logic [ACC_W-1:0] exp_res_b = '0;
  logic             exp_clip  = 1'b0;

  adc_meas_accum_if #(.ADC_W(ADC_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

  adc_meas_accum #(.ADC_W(ADC_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Offset-binary code to its signed value.
  function automatic longint conv(input logic [ADC_W-1:0] c);
    return longint'(c) - 2048;
  endfunction

  function automatic bit is_clip(input logic [ADC_W-1:0] c);
    return (c == '0) || (c == {ADC_W{1'b1}});
  endfunction

  function automatic logic [ADC_W-1:0] rand_code();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return {ADC_W{1'b1}};
    return ADC_W'($urandom);
  endfunction

  // One measurement of n pairs; code < 0 selects random codes, period 0 random valid gaps.
  task automatic run_meas(input int n, input int period, input int code_a, input int code_b,
                          input bit hold_start, input string tag);
    longint           sum_a = 0;
    longint           sum_b = 0;
    bit               clp = 1'b0;
    int               sent = 0;
    int               cyc = 0;
    int               lat;
    bit               seen;
    bit               v;
    logic [ADC_W-1:0] a, b;
    bus.num_samples = CNT_W'(n);
    bus.abort       = 1'b0;
    bus.adc_valid   = 1'b0;
    bus.start       = 1'b1;
    tick();
    bus.start       = hold_start;
    bus.num_samples = CNT_W'($urandom);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start(%s): got %b expected 1", tag, bus.busy);
    end
    while (sent < n) begin
      cyc++;
      v = (period > 0) ? ((cyc % period) == 0) : ($urandom_range(0, 2) == 0);
      a = (code_a < 0) ? rand_code() : ADC_W'(code_a);
      b = (code_b < 0) ? rand_code() : ADC_W'(code_b);
      bus.adc_valid = v;
      bus.adc_a     = a;
      bus.adc_b     = b;
      if (v) begin
        sum_a += conv(a);
        sum_b += conv(b);
        clp   |= is_clip(a) | is_clip(b);
        sent++;
      end
      tick();
      checks++;
      if (bus.meas_done !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL acq_status(%s): got done=%b busy=%b expected done=0 busy=1",
                 tag, bus.meas_done, bus.busy);
      end
    end
    bus.adc_valid = 1'b0;
    bus.start     = 1'b0;
    bus.adc_a     = ADC_W'($urandom);
    bus.adc_b     = ADC_W'($urandom);
    lat  = 1;
    seen = bus.meas_done;
    while (!seen && lat < 10) begin
      tick();
      lat++;
      seen = bus.meas_done;
    end
    exp_res_a = ACC_W'(sum_a);
    exp_res_b = ACC_W'(sum_b);
    exp_clip  = clp;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL meas_done_timeout(%s): got no pulse within %0d cycles expected one", tag, lat);
    end
    checks++;
    if (lat != ((n == 0) ? 2 : 3)) begin
      errors++;
      $display("FAIL done_latency(%s): got %0d expected %0d", tag, lat, (n == 0) ? 2 : 3);
    end
    checks++;
    if (bus.res_a !== exp_res_a) begin
      errors++;
      $display("FAIL res_a(%s): got %h expected %h", tag, bus.res_a, exp_res_a);
    end
    checks++;
    if (bus.res_b !== exp_res_b) begin
      errors++;
      $display("FAIL res_b(%s): got %h expected %h", tag, bus.res_b, exp_res_b);
    end
    checks++;
    if (bus.clip !== exp_clip || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_status(%s): got clip=%b busy=%b expected clip=%b busy=0",
               tag, bus.clip, bus.busy, exp_clip);
    end
    tick();
    checks++;
    if (bus.meas_done !== 1'b0 || bus.res_a !== exp_res_a) begin
      errors++;
      $display("FAIL done_pulse_width(%s): got done=%b res_a=%h expected done=0 res_a=%h",
               tag, bus.meas_done, bus.res_a, exp_res_a);
    end
  endtask

  task automatic test_readback(input string tag);
    logic [ACC_W-1:0] w;
    logic [7:0]       exp_b;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = 3'(i);
      tick();
      w     = (i < 4) ? exp_res_a : exp_res_b;
      exp_b = 8'(w >> (8 * (i % 4)));
      checks++;
      if (bus.rd_data !== exp_b) begin
        errors++;
        $display("FAIL rd_data(%s addr %0d): got %h expected %h", tag, i, bus.rd_data, exp_b);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.meas_done !== 1'b0 || bus.clip !== 1'b0 ||
        bus.res_a !== '0 || bus.res_b !== '0 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b clip=%b res_a=%h res_b=%h rd=%h expected all 0",
               bus.busy, bus.meas_done, bus.clip, bus.res_a, bus.res_b, bus.rd_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_meas(4, 3, 'h800, 'hFFF, 1'b0, "basic");
    checks++;
    if (bus.res_a !== 32'd0 || bus.res_b !== 32'd8188 || bus.clip !== 1'b1) begin
      errors++;
      $display("FAIL basic_values: got res_a=%0d res_b=%0d clip=%b expected 0 8188 1",
               $signed(bus.res_a), $signed(bus.res_b), bus.clip);
    end
  endtask

  task automatic test_zero();
    run_meas(0, 1, -1, -1, 1'b0, "zero");
    test_readback("zero");
  endtask

  task automatic test_abort();
    bit stray_done = 1'b0;
    run_meas(3, 0, -1, -1, 1'b0, "pre_abort");
    bus.num_samples = CNT_W'(100);
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.adc_valid = 1'b1;
      bus.adc_a     = 12'h900;
      bus.adc_b     = rand_code();
      tick();
    end
    bus.adc_valid = 1'b0;
    bus.abort     = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b expected 0", bus.busy);
    end
    for (int i = 0; i < 6; i++) begin
      bus.adc_valid = 1'b1;
      tick();
      stray_done |= bus.meas_done;
    end
    bus.adc_valid = 1'b0;
    checks++;
    if (stray_done || bus.res_a !== exp_res_a || bus.res_b !== exp_res_b || bus.clip !== exp_clip) begin
      errors++;
      $display("FAIL abort_hold: got done_seen=%b res_a=%h res_b=%h clip=%b expected 0 %h %h %b",
               stray_done, bus.res_a, bus.res_b, bus.clip, exp_res_a, exp_res_b, exp_clip);
    end
    run_meas(2, 1, 'h900, 'h900, 1'b0, "after_abort");
    checks++;
    if (bus.res_a !== 32'd512) begin
      errors++;
      $display("FAIL after_abort_value: got %0d expected 512", $signed(bus.res_a));
    end
  endtask

  task automatic test_start_ignored();
    bit stray_done = 1'b0;
    run_meas(8, 0, -1, -1, 1'b1, "start_held");
    bus.num_samples = CNT_W'(5);
    bus.start       = 1'b1;
    bus.abort       = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: got busy=%b expected 0", bus.busy);
    end
    bus.num_samples = CNT_W'(20);
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.adc_valid = 1'b1;
      bus.adc_a     = rand_code();
      bus.adc_b     = rand_code();
      tick();
    end
    bus.adc_valid = 1'b0;
    bus.start     = 1'b1;
    bus.abort     = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_acq: got busy=%b expected 0", bus.busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      stray_done |= bus.meas_done;
    end
    checks++;
    if (stray_done || bus.res_a !== exp_res_a || bus.res_b !== exp_res_b) begin
      errors++;
      $display("FAIL start_abort_hold: got done_seen=%b res_a=%h res_b=%h expected 0 %h %h",
               stray_done, bus.res_a, bus.res_b, exp_res_a, exp_res_b);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      run_meas(int'($urandom_range(1, 40)), 0, -1, -1, 1'b0, $sformatf("b2b_%0d", k));
    end
    run_meas(0, 1, -1, -1, 1'b0, "b2b_zero");
    run_meas(int'($urandom_range(1, 40)), 1, -1, -1, 1'b0, "b2b_dense");
    test_readback("b2b");
  endtask

  task automatic test_reset_mid();
    bus.rd_addr     = 3'd0;
    bus.num_samples = CNT_W'(50);
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.adc_valid = 1'b1;
      bus.adc_a     = {ADC_W{1'b1}};
      bus.adc_b     = '0;
      tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.meas_done !== 1'b0 || bus.clip !== 1'b0 ||
        bus.res_a !== '0 || bus.res_b !== '0 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b clip=%b res_a=%h res_b=%h rd=%h expected all 0",
               bus.busy, bus.meas_done, bus.clip, bus.res_a, bus.res_b, bus.rd_data);
    end
    rst           = 1'b0;
    bus.adc_valid = 1'b0;
    exp_res_a     = '0;
    exp_res_b     = '0;
    exp_clip      = 1'b0;
    tick();
    run_meas(5, 0, -1, -1, 1'b0, "post_reset");
  endtask

  task automatic test_long();
    run_meas(65535, 1, 'h000, 'hFFF, 1'b0, "long");
    test_readback("long");
  endtask

  initial begin
    rst             = 1'b1;
    bus.adc_valid   = 1'b0;
    bus.adc_a       = '0;
    bus.adc_b       = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.num_samples = '0;
    bus.rd_addr     = '0;
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_long();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
